serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial add/subtract controller that time-shares one full_adder cell across WIDTH-bit operands, one bit per clock, LSB first.
- Start/busy/done handshake so board logic (switch inputs, LED outputs) can request an operation and read a registered result.
- Sits between the switch-capture logic and the LED display. It replaces a ripple chain of adders with a single shared cell plus sequencing.

Parameters:
WIDTH, 4, operand width in bits (>= 2); result is WIDTH+1 bits
CNT_W, $clog2(WIDTH), width of the internal bit counter (derived, not overridden)

Ports:
clk  in  1  system clock; all logic rising-edge
rst  in  1  synchronous reset, active-high
start  in  1  request pulse; sampled only in IDLE
sub  in  1  0 = add (op_a + op_b), 1 = subtract (op_a - op_b); sampled with start
op_a  in  WIDTH  operand A; sampled with start
op_b  in  WIDTH  operand B; sampled with start
busy  out  1  high while bits are being processed (RUN state)
done  out  1  one-cycle pulse: result valid this cycle and later
result  out  WIDTH+1  {carry_out, sum[WIDTH-1:0]}; held until the next done

Behaviour:
- Single clock domain: clk, synchronous active-high rst. No async logic.
- Reset (any state, including mid-RUN): state=IDLE, busy=0, done=0, result=0, counter=0, carry flop=0, shift registers=0. The in-flight operation is discarded with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1: latch a_sh<=op_a, b_sh<=(sub ? ~op_b : op_b), carry<=sub, cnt<=0, state<=RUN.
  - Otherwise hold.
- RUN, each cycle:
  - Shared full_adder computes s, co from (a_sh[0], b_sh[0], carry).
  - s_sh <= {s, s_sh[WIDTH-1:1]}; a_sh, b_sh shift right by 1; carry<=co; cnt<=cnt+1.
  - When cnt==WIDTH-1: state<=DONE and final_carry<=co (the last bit is still shifted in).
- DONE, exactly one cycle:
  - done=1; result={final_carry, s_sh} is registered at entry to DONE, so it is valid when done=1.
  - state<=IDLE next cycle. start is ignored in DONE.
- busy=1 exactly in RUN; done=1 exactly in DONE; both are registered outputs (no combinational path from inputs).
- Latency: start high in cycle T -> busy in T+1..T+WIDTH -> done in T+WIDTH+1 -> next start accepted from T+WIDTH+2.
- start while busy or in DONE: ignored, no queuing. Changes to op_a/op_b/sub after acceptance do not affect the operation in flight.
- Subtract semantics: two's complement via inverted B and carry-in 1.
  - result[WIDTH]=1 means no borrow (op_a >= op_b unsigned).
  - result[WIDTH-1:0] is the WIDTH-bit difference modulo 2^WIDTH.
- Add semantics: result is the full unsigned sum, no overflow possible (WIDTH+1 bits).
- Counter wraps only via the state transition; cnt is never compared beyond WIDTH-1.
- result is not cleared on start; it changes only at DONE entry or on reset.

Decomposition:
- Shared package serial_adder_pkg:
  - state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - op encoding constants: OP_ADD=1'b0, OP_SUB=1'b1.
- Sub-module: one instance of the team's existing full_adder (carry_in, in1, in2 -> sum, carry) as the shared datapath cell.
- Controller FSM, counter, and shift registers stay in serial_adder_ctrl.

Test Plan:
- WIDTH=4, rst high 2 cycles, then idle 3 cycles -> busy=0, done=0, result=5'b00000 throughout.
- start with op_a=3, op_b=5, sub=0 in cycle T -> busy high T+1..T+4, done only at T+5, result=5'b01000, held until next done.
- op_a=15, op_b=15, sub=0 -> result=5'b11110. Then back-to-back start at T+6 with op_a=5, op_b=3, sub=1 -> result=5'b10010 (no borrow, diff 2).
- op_a=3, op_b=5, sub=1 -> result=5'b01110 (borrow, diff 4'b1110). Pulse start again during RUN and during DONE with op_a=0, op_b=0 -> ignored, exactly one done, result unchanged by the ignored requests.
- Start 9+6, assert rst at T+2 for one cycle -> busy drops next cycle, no done pulse, result=0. A new start of 1+1 afterwards -> result=5'b00010 with normal latency.
- Randomized sweep of all 256 (op_a, op_b) pairs x both ops against a reference model -> every result matches, and done count equals accepted start count.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared encodings for the bit-serial add/subtract controller:
// FSM state values and the add/subtract select.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the single datapath cell time-shared by the serial controller.
module full_adder (
  input  logic carry_in,
  input  logic in1,
  input  logic in2,
  output logic sum,
  output logic carry
);

  assign sum   = in1 ^ in2 ^ carry_in;
  assign carry = (in1 & in2) | (carry_in & (in1 ^ in2));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: walks WIDTH-bit operands LSB first through
// one shared full_adder and presents a registered {carry, sum} with a done pulse.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   result
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_co;
  logic             last_bit;

  full_adder u_fa (
    .carry_in(carry),
    .in1     (a_sh[0]),
    .in2     (b_sh[0]),
    .sum     (fa_sum),
    .carry   (fa_co)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // The unused encoding 2'd3 falls through to IDLE so a corrupted state recovers.
  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE: next_state = start ? ST_RUN : ST_IDLE;
      ST_RUN:  next_state = last_bit ? ST_DONE : ST_RUN;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // busy/done are flopped from the next state so they track the state register exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == ST_RUN);
      done  <= (next_state == ST_DONE);
    end
  end

  // Subtraction is A + ~B + 1, so the carry flop doubles as the carry-in of one.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      s_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= op_a;
            b_sh  <= (sub == OP_SUB) ? ~op_b : op_b;
            carry <= sub;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          s_sh  <= {fa_sum, s_sh[WIDTH-1:1]};
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_co;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            result <= {fa_co, fa_sum, s_sh[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: stimulus pushes expected results,
// an independent monitor pops and compares on every done pulse.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             sub = 1'b0;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   result;

  int checks = 0;
  int passes = 0;
  int dones_seen = 0;
  int accepted = 0;
  logic [WIDTH:0] exp_q[$];

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .op_a  (op_a),
    .op_b  (op_b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  function automatic logic [WIDTH:0] refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic s);
    logic [WIDTH-1:0] diff;
    if (s) begin
      diff = a - b;
      return {(a >= b), diff};
    end
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Drives one start pulse; returns one tick after the edge that samples it.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                               input logic [WIDTH:0] expv, input bit expect_done);
    op_a  = a;
    op_b  = b;
    sub   = s;
    start = 1'b1;
    if (expect_done) begin
      exp_q.push_back(expv);
      accepted++;
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic runToDone(output int busy_cycles, output int lat);
    busy_cycles = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) busy_cycles++;
    end while (!done && lat < 50);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      dones_seen++;
      checkOutput("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) checkOutput("result", 32'(result), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired busy=%0b done=%0b", busy, done);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bc, lat, d0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_result", 32'(result), 32'd0);
    end
    @(posedge clk);
    #1;

    applyStimulus(4'd3, 4'd5, 1'b0, 5'b01000, 1'b1);
    runToDone(bc, lat);
    checkOutput("add_latency", 32'(lat), 32'd5);
    checkOutput("add_busy_cycles", 32'(bc), 32'd4);
    checkOutput("done_busy_low", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("result_held_idle", 32'(result), 32'b01000);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    @(posedge clk);
    #1;

    applyStimulus(4'd15, 4'd15, 1'b0, 5'b11110, 1'b1);
    runToDone(bc, lat);
    checkOutput("max_add_latency", 32'(lat), 32'd5);
    @(posedge clk);
    #1;
    applyStimulus(4'd5, 4'd3, 1'b1, 5'b10010, 1'b1);
    @(negedge clk);
    checkOutput("result_held_run", 32'(result), 32'b11110);
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    runToDone(bc, lat);
    checkOutput("b2b_latency", 32'(lat), 32'd4);
    @(posedge clk);
    #1;

    d0 = dones_seen;
    applyStimulus(4'd3, 4'd5, 1'b1, 5'b01110, 1'b1);
    repeat (2) @(negedge clk);
    op_a = 4'd0; op_b = 4'd0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 20);
    checkOutput("ignore_run_latency", 32'(lat), 32'd3);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("ignored_single_done", 32'(dones_seen - d0), 32'd1);
    checkOutput("ignored_result", 32'(result), 32'b01110);
    checkOutput("ignored_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    d0 = dones_seen;
    applyStimulus(4'd9, 4'd6, 1'b0, 5'b01111, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_result", 32'(result), 32'd0);
    repeat (8) @(negedge clk);
    checkOutput("abort_no_done", 32'(dones_seen - d0), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(4'd1, 4'd1, 1'b0, 5'b00010, 1'b1);
    runToDone(bc, lat);
    checkOutput("post_reset_latency", 32'(lat), 32'd5);
    @(posedge clk);
    #1;

    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          applyStimulus(4'(a), 4'(b), 1'(s), refModel(4'(a), 4'(b), 1'(s)), 1'b1);
          runToDone(bc, lat);
          if (lat >= 50) checkOutput("sweep_timeout", 32'(lat), 32'd5);
          @(posedge clk);
          #1;
        end
      end
    end

    repeat (4) @(negedge clk);
    checkOutput("done_count", 32'(dones_seen), 32'(accepted));
    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
